// File: rtl/csr_req_master_if.sv
// csr_req_master_if: host command/response and CSR-unit signals of csr_req_master.
interface csr_req_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [11:0] cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic [1:0]  cmd_op_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_data_o;
  logic [1:0]  csr_op_o;
  logic        csr_we_o;
  logic [31:0] csr_data_i;
  logic [15:0] txn_cnt_o;
  modport master (
    input  cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_op_i, rsp_ready_i, csr_data_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           csr_addr_o, csr_data_o, csr_op_o, csr_we_o, txn_cnt_o
  );
  modport slave (
    output cmd_valid_i, cmd_addr_i, cmd_data_i, cmd_op_i, rsp_ready_i, csr_data_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           csr_addr_o, csr_data_o, csr_op_o, csr_we_o, txn_cnt_o
  );
endinterface

// File: rtl/csr_req_master.sv
// csr_req_master: sequences one host CSR command as read-then-optional-write and returns the old value.
// CSR_REQ_RO_CHECK_EN: when defined, needed writes to addr[11:10] == 2'b11 are rejected with rsp_err_o.
module csr_req_master (
  input logic               clk_i,
  input logic               rst_ni,
  csr_req_master_if.master  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] txn_cnt_q, txn_cnt_d;
  logic        cmd_hs, rsp_hs, wr_need, wr_rej;
  assign cmd_hs  = bus.cmd_valid_i && bus.cmd_ready_o;
  assign rsp_hs  = bus.rsp_valid_o && bus.rsp_ready_i;
  // set/clear with a zero mask and read-only ops leave the CSR untouched
  assign wr_need = (op_q == 2'b00) || (op_q != 2'b11 && data_q != '0);
`ifdef CSR_REQ_RO_CHECK_EN
  logic err_q, err_d;
  assign wr_rej        = wr_need && addr_q[11:10] == 2'b11;
  assign err_d         = (state_q == READ) ? wr_rej : err_q;
  assign bus.rsp_err_o = err_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) err_q <= 1'b0;
    else         err_q <= err_d;
`else
  assign wr_rej        = 1'b0;
  assign bus.rsp_err_o = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cmd_hs ? READ : IDLE;
      READ:    state_d = (wr_need && !wr_rej) ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = rsp_hs ? IDLE : RESP;
    endcase
  end
  assign addr_d    = cmd_hs ? bus.cmd_addr_i : addr_q;
  assign data_d    = cmd_hs ? bus.cmd_data_i : data_q;
  assign op_d      = cmd_hs ? bus.cmd_op_i   : op_q;
  assign rdata_d   = (state_q == READ) ? bus.csr_data_i : rdata_q;
  assign txn_cnt_d = txn_cnt_q + 16'(rsp_hs);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= '0;
      rdata_q   <= '0;
      txn_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      op_q      <= op_d;
      rdata_q   <= rdata_d;
      txn_cnt_q <= txn_cnt_d;
    end
  // strobes decode straight from the state flop so reset drops them asynchronously
  assign bus.cmd_ready_o = rst_ni && state_q == IDLE;
  assign bus.rsp_valid_o = state_q == RESP;
  assign bus.csr_we_o    = state_q == WRITE;
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.csr_addr_o  = addr_q;
  assign bus.csr_data_o  = data_q;
  assign bus.csr_op_o    = op_q;
  assign bus.txn_cnt_o   = txn_cnt_q;
endmodule

// File: tb/tb_csr_req_master.sv
// tb_csr_req_master: directed bench for csr_req_master with a cycle-timed transaction model.
// Honours CSR_REQ_RO_CHECK_EN the same way as the design.
module tb_csr_req_master;
`ifdef CSR_REQ_RO_CHECK_EN
  localparam bit RO = 1'b1;
`else
  localparam bit RO = 1'b0;
`endif
  localparam logic [31:0] VEND_ID = 32'h0000_0489;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  csr_req_master_if bus();
  csr_req_master dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus.master));
  initial forever #5 clk_i = ~clk_i;
  logic [31:0] csr_mem [4096];
  logic        ld_en = 1'b0;
  logic [11:0] ld_a = '0;
  logic [31:0] ld_v = '0;
  int          we_cnt = 0;
  logic [31:0] wr_d = '0;
  logic [1:0]  wr_o = '0;
  assign bus.csr_data_i = csr_mem[bus.csr_addr_o];
  always @(posedge clk_i) begin
    if (ld_en) csr_mem[ld_a] <= ld_v;
    else if (bus.csr_we_o) begin
      csr_mem[bus.csr_addr_o] <= (bus.csr_op_o == 2'b00) ? bus.csr_data_o :
                                 (bus.csr_op_o == 2'b01) ? csr_mem[bus.csr_addr_o] | bus.csr_data_o :
                                                           csr_mem[bus.csr_addr_o] & ~bus.csr_data_o;
      we_cnt <= we_cnt + 1;
      wr_d   <= bus.csr_data_o;
      wr_o   <= bus.csr_op_o;
    end
  end
  function automatic logic f_need(input logic [1:0] o, input logic [31:0] d);
    return o == 2'b00 || (o != 2'b11 && d != 32'h0);
  endfunction
  function automatic logic f_rej(input logic [11:0] a);
    return RO && a[11:10] == 2'b11;
  endfunction
  // model: a command accepted in cycle t0 responds from t0+2 (+1 if it writes) until rsp_ready_i
  int          cyc = 0;
  logic        pre = 1'b0;
  logic        m_busy = 1'b0, m_w = 1'b0, m_err = 1'b0;
  int          m_t0 = 0;
  logic [11:0] m_a = '0;
  logic [31:0] m_d = '0, m_rd = '0;
  logic [1:0]  m_o = '0;
  logic [15:0] m_cnt = '0;
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
    end else begin
      cyc <= cyc + 1;
      if (!m_busy && bus.cmd_valid_i) begin
        m_busy <= 1'b1;
        m_t0   <= cyc;
        m_a    <= bus.cmd_addr_i;
        m_d    <= bus.cmd_data_i;
        m_o    <= bus.cmd_op_i;
        m_w    <= f_need(bus.cmd_op_i, bus.cmd_data_i) && !f_rej(bus.cmd_addr_i);
        m_err  <= f_need(bus.cmd_op_i, bus.cmd_data_i) && f_rej(bus.cmd_addr_i);
        m_rd   <= csr_mem[bus.cmd_addr_i];
      end else if (m_busy && cyc >= m_t0 + 2 + int'(m_w) && bus.rsp_ready_i) begin
        m_busy <= 1'b0;
        m_cnt  <= m_cnt + 16'd1;
      end
      if (pre) m_cnt <= 16'hFFFF;
    end
  end
  int vec = 0, miss = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic monitor();
    int k;
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      k = cyc - m_t0;
      chk("cmd_ready", 32'(bus.cmd_ready_o), 32'(!m_busy && rst_ni));
      chk("csr_we", 32'(bus.csr_we_o), 32'(m_busy && m_w && k == 2));
      chk("rsp_valid", 32'(bus.rsp_valid_o), 32'(m_busy && k >= 2 + int'(m_w)));
      chk("txn_cnt", 32'(bus.txn_cnt_o), 32'(m_cnt));
      if (m_busy && k >= 1) begin
        chk("csr_addr", 32'(bus.csr_addr_o), 32'(m_a));
        chk("csr_data", bus.csr_data_o, m_d);
        chk("csr_op", 32'(bus.csr_op_o), 32'(m_o));
      end
      if (m_busy && k >= 2) begin
        chk("rsp_rdata", bus.rsp_rdata_o, m_rd);
        chk("rsp_err", 32'(bus.rsp_err_o), 32'(m_err));
      end
    end
  endtask
  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    @(posedge clk_i); #2;
    ld_a = a; ld_v = v; ld_en = 1'b1;
    @(posedge clk_i); #2;
    ld_en = 1'b0;
  endtask
  task automatic send(input logic [11:0] a, input logic [31:0] d, input logic [1:0] o, input string nm);
    int n = 0;
    @(posedge clk_i); #2;
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = a; bus.cmd_data_i = d; bus.cmd_op_i = o;
    while (!bus.cmd_ready_o && n < 20) begin @(posedge clk_i); #2; n++; end
    @(posedge clk_i); #2;
    bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = ~a; bus.cmd_data_i = ~d; bus.cmd_op_i = ~o;
    chk({nm, " accept timeout"}, 32'(n < 20), 32'd1);
  endtask
  task automatic txn(input logic [11:0] a, input logic [31:0] d, input logic [1:0] o, input int hold,
                     input logic [31:0] exp_rd, input logic exp_wr, input logic exp_e, input string nm);
    int lat = 1, w0 = we_cnt;
    logic [31:0] rd;
    send(a, d, o, nm);
    while (!bus.rsp_valid_o && lat < 20) begin @(posedge clk_i); #2; lat++; end
    rd = bus.rsp_rdata_o;
    chk({nm, " latency"}, 32'(lat), exp_wr ? 32'd3 : 32'd2);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #2;
      chk({nm, " hold valid"}, 32'(bus.rsp_valid_o), 32'd1);
      chk({nm, " hold rdata"}, bus.rsp_rdata_o, rd);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk_i); #2;
    bus.rsp_ready_i = 1'b0;
    chk({nm, " rdata"}, rd, exp_rd);
    chk({nm, " err"}, 32'(bus.rsp_err_o), 32'(exp_e));
    chk({nm, " writes"}, 32'(we_cnt - w0), 32'(exp_wr));
  endtask
  logic [15:0] ecnt = '0;
  initial begin
    bus.cmd_valid_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_data_i = '0; bus.cmd_op_i = '0;
    bus.rsp_ready_i = 1'b0;
    fork monitor(); join_none
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("reset csr_we", 32'(bus.csr_we_o), 32'd0);
    chk("reset csr_addr", 32'(bus.csr_addr_o), 32'd0);
    chk("reset txn_cnt", 32'(bus.txn_cnt_o), 32'd0);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #2;
    chk("ready after reset", 32'(bus.cmd_ready_o), 32'd1);
    preload(12'h340, 32'h0000_0011);
    preload(12'hC00, 32'h0000_002A);
    preload(12'h300, 32'h0000_0005);
    preload(12'hF11, VEND_ID);
    preload(12'h305, 32'h0000_0077);
    txn(12'h340, 32'hDEAD_BEEF, 2'b00, 0, 32'h0000_0011, 1'b1, 1'b0, "rw340");
    ecnt++;
    chk("rw340 wdata", wr_d, 32'hDEAD_BEEF);
    chk("rw340 wop", 32'(wr_o), 32'd0);
    chk("rw340 cnt", 32'(bus.txn_cnt_o), 32'(ecnt));
    txn(12'hC00, 32'hFFFF_FFFF, 2'b11, 0, 32'h0000_002A, 1'b0, 1'b0, "ro_c00");
    ecnt++;
    txn(12'h300, 32'h0, 2'b01, 0, 32'h0000_0005, 1'b0, 1'b0, "rs0");
    ecnt++;
    txn(12'h300, 32'h8, 2'b01, 0, 32'h0000_0005, 1'b1, 1'b0, "rs8");
    ecnt++;
    chk("rs8 wdata", wr_d, 32'h8);
    chk("rs8 wop", 32'(wr_o), 32'd1);
    txn(12'h300, 32'h4, 2'b10, 0, 32'h0000_000D, 1'b1, 1'b0, "rc4");
    ecnt++;
    chk("rc4 csr", csr_mem[12'h300], 32'h0000_0009);
    txn(12'hF11, 32'h1, 2'b00, 0, VEND_ID, !RO, RO, "rw_f11");
    ecnt++;
    txn(12'hC00, 32'h0, 2'b11, 5, 32'h0000_002A, 1'b0, 1'b0, "hold5");
    ecnt++;
    chk("cnt after hold", 32'(bus.txn_cnt_o), 32'(ecnt));
    bus.cmd_valid_i = 1'b1; bus.cmd_addr_i = 12'hC00; bus.cmd_op_i = 2'b11; bus.rsp_ready_i = 1'b1;
    repeat (12) @(posedge clk_i);
    #2;
    bus.cmd_valid_i = 1'b0; bus.rsp_ready_i = 1'b0;
    ecnt += 16'd4;
    chk("b2b cnt", 32'(bus.txn_cnt_o), 32'(ecnt));
    @(negedge clk_i); #1;
    force dut.txn_cnt_q = 16'hFFFF;
    pre = 1'b1;
    @(posedge clk_i); #2;
    pre = 1'b0;
    release dut.txn_cnt_q;
    chk("preload cnt", 32'(bus.txn_cnt_o), 32'h0000_FFFF);
    txn(12'h340, 32'h0, 2'b11, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, "wrap");
    chk("wrap cnt", 32'(bus.txn_cnt_o), 32'h0000_0000);
    txn(12'h340, 32'h0, 2'b11, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, "post_wrap");
    send(12'h305, 32'h5, 2'b00, "rst_mid");
    @(posedge clk_i); #2;
    chk("rst_mid we before", 32'(bus.csr_we_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_mid we dropped", 32'(bus.csr_we_o), 32'd0);
    chk("rst_mid rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    chk("rst_mid cnt", 32'(bus.txn_cnt_o), 32'd0);
    @(posedge clk_i); #2;
    rst_ni = 1'b1;
    @(posedge clk_i); #2;
    chk("rst_mid ready", 32'(bus.cmd_ready_o), 32'd1);
    chk("rst_mid csr kept", csr_mem[12'h305], 32'h0000_0077);
    chk("rst_mid csr_addr", 32'(bus.csr_addr_o), 32'd0);
    repeat (3) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/csr_req_master.md
CSR_REQ_MASTER -- requirements
Module: csr_req_master

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous active-low reset: clk_i and rst_ni.
REQ-002 clk_i  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst_ni  input  1  asynchronous active-low reset.
REQ-004 cmd_valid_i  input  1  command request from host/debug side.
REQ-005 cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
REQ-006 cmd_addr_i  input  12  target CSR address.
REQ-007 cmd_data_i  input  32  operand.
REQ-008 cmd_op_i  input  2  00 RW, 01 RS, 10 RC, 11 read-only.
REQ-009 rsp_valid_o  output  1  response available.
REQ-010 rsp_ready_i  input  1  host accepts the response.
REQ-011 rsp_rdata_o  output  32  CSR value read before any write.
REQ-012 rsp_err_o  output  1  command rejected (write to read-only CSR).
REQ-013 csr_addr_o  output  12  address to CSR unit.
REQ-014 csr_data_o  output  32  operand to CSR unit.
REQ-015 csr_op_o  output  2  op to CSR unit (same encoding as cmd_op_i).
REQ-016 csr_we_o  output  1  single-cycle write strobe to CSR unit.
REQ-017 csr_data_i  input  32  combinational read data from CSR unit for csr_addr_o.
REQ-018 txn_cnt_o  output  16  count of completed responses.

Function
REQ-019 FSM states SHALL be IDLE, READ, WRITE, RESP; only IDLE asserts cmd_ready_o.
REQ-020 On handshake in IDLE (cycle T), addr/data/op SHALL be registered; inputs are don't-care afterwards; next state READ.
REQ-021 READ (T+1): csr_addr_o = registered addr, csr_we_o = 0; csr_data_i SHALL be captured into rsp_rdata_o at the end of the cycle.
REQ-022 Write needed: op RW, or op RS/RC with operand != 0; op 11 or RS/RC with operand 0 SHALL NOT write.
REQ-023 Write needed and not rejected: READ -> WRITE; WRITE (T+2) asserts csr_we_o for exactly one cycle with csr_addr_o/csr_data_o/csr_op_o valid; then RESP (T+3).
REQ-024 No write or rejected: READ -> RESP (T+2); csr_we_o stays 0.
REQ-025 RESP: rsp_valid_o = 1; rsp_rdata_o and rsp_err_o SHALL be held stable until rsp_ready_i; on rsp_valid_o && rsp_ready_i -> IDLE next cycle.
REQ-026 rsp_ready_i high on the first RESP cycle SHALL complete in one cycle; a new command SHALL NOT be accepted in that same cycle (back-to-back minimum 4 cycles for reads).
REQ-027 txn_cnt_o SHALL increment by 1 on each response handshake, wrapping 0xFFFF -> 0x0000; errored responses count.
REQ-028 csr_addr_o/csr_data_o/csr_op_o SHALL hold registered values outside IDLE and 0 after reset; csr_we_o SHALL be high only in WRITE.
REQ-029 rsp_rdata_o SHALL NOT change in WRITE (old value returned, not new).

Reset
REQ-030 rst_ni low SHALL force, asynchronously, state IDLE and all outputs to 0 except cmd_ready_o, which SHALL be 1 after reset deasserts.
REQ-031 Reset mid-transaction (READ/WRITE/RESP) SHALL drop csr_we_o and rsp_valid_o immediately; the transaction is discarded and not counted.

Configuration
REQ-032 Macro CSR_REQ_RO_CHECK_EN defined: a needed write to addr[11:10] == 2'b11 SHALL be rejected (rsp_err_o = 1, rdata still returned, no csr_we_o).
REQ-033 Macro undefined: no address check; rsp_err_o SHALL be tied 0 and the write proceeds per REQ-023.

Verification
REQ-034 Reset then cmd RW addr 0x340 data 0xDEADBEEF, CSR reads 0x00000011 -> csr_we_o one cycle at T+2 with data 0xDEADBEEF op 00; rsp_valid_o at T+3, rdata 0x00000011, err 0, txn_cnt_o 1.
REQ-035 Cmd op 11 addr 0xC00, CSR reads 0x0000002A -> no csr_we_o; rsp at T+2 rdata 0x0000002A.
REQ-036 Cmd RS addr 0x300 data 0 -> no write; RS data 0x8 -> write pulse op 01 data 0x8.
REQ-037 With CSR_REQ_RO_CHECK_EN: RW addr 0xF11 data 0x1 -> no write, rsp_err_o 1, rdata = VEND_ID; without macro -> write pulse, err 0.
REQ-038 Hold rsp_ready_i low 5 cycles in RESP -> rsp_valid_o/rdata stable, cmd_ready_o 0; preload 0xFFFF responses then one more -> txn_cnt_o 0x0000.
REQ-039 Assert rst_ni low during WRITE -> csr_we_o 0 same cycle, IDLE after release, txn_cnt_o unchanged-to-0.
